inst_fetch: RTL and testbench

- Instruction-fetch stage, directly upstream of the direct-mapped instruction cache.
- Holds the PC and looks it up in the cache each cycle.
- On a miss, reads the 32-bit instruction one byte at a time through the memory controller, then writes the word into the cache.
- Delivers (pc, instruction) pairs to the IF/ID register; honours downstream stall and branch/jump redirect.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch.sv | 131 +++++++++++++
 tb/tb_inst_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [7:0]  byte_t;

  localparam inst_t      ZERO_WORD        = 32'h0000_0000;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FILL   = 2'd1,
    WRITE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: looks the PC up in the instruction cache, fills
// misses one byte at a time from the memory controller, and hands
// (pc, instruction) pairs to IF/ID.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOOKUP | present pc to cache; deliver on hit, start fill on miss
// FILL   | request bytes pc+byte_cnt, assemble little-endian into buffer
// WRITE  | one cycle writing buffer into the cache line for pc
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  stall_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  input  logic [INST_WIDTH-1:0] cache_data_i,
  input  logic                  cache_hit_i,
  output logic                  cache_work_o,
  output logic [INST_WIDTH-1:0] cache_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [7:0]            mem_data_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam int BYTES = INST_WIDTH / 8;
  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(BYTES);

  fetch_state_t            state, state_n;
  logic [ADDR_WIDTH-1:0]   pc, pc_n;
  logic [CNT_W-1:0]        byte_cnt, cnt_n;
  logic [INST_WIDTH-1:0]   buffer, buf_n;
  logic                    valid_n;
  logic [INST_WIDTH-1:0]   inst_n;
  logic [ADDR_WIDTH-1:0]   pco_n;
  logic [ADDR_WIDTH-1:0]   fill_addr;

  assign fill_addr = pc + {{(ADDR_WIDTH-CNT_W){1'b0}}, byte_cnt};

  // Cache and memory-side outputs decode straight from the current state.
  always_comb begin
    cache_addr_o = pc;
    cache_data_o = buffer;
    cache_work_o = rdy && (state == WRITE);
    mem_req_o    = rdy && (state == FILL);
    mem_addr_o   = (state == FILL) ? fill_addr : pc;
  end

  // Next-state and next-output logic; a redirect overrides everything.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = byte_cnt;
    buf_n   = buffer;
    valid_n = inst_valid_o;
    inst_n  = inst_o;
    pco_n   = pc_o;
    if (jump_i) begin
      pc_n    = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
      state_n = LOOKUP;
      cnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          if (cache_hit_i) begin
            if (!stall_i) begin
              valid_n = 1'b1;
              inst_n  = cache_data_i;
              pco_n   = pc;
              pc_n    = pc + PC_STEP;
            end
          end else begin
            state_n = FILL;
            cnt_n   = '0;
            if (!stall_i) valid_n = 1'b0;
          end
        end
        FILL: begin
          // Once IF/ID has taken the last instruction, nothing is pending.
          if (!stall_i) valid_n = 1'b0;
          if (mem_valid_i) begin
            buf_n[8*byte_cnt +: 8] = mem_data_i;
            cnt_n = byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) state_n = WRITE;
          end
        end
        WRITE: begin
          if (!stall_i) valid_n = 1'b0;
          state_n = LOOKUP;
        end
        default: state_n = LOOKUP;
      endcase
    end
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOOKUP;
      pc           <= RESET_PC;
      byte_cnt     <= '0;
      buffer       <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
    end else if (rdy) begin
      state        <= state_n;
      pc           <= pc_n;
      byte_cnt     <= cnt_n;
      buffer       <= buf_n;
      inst_valid_o <= valid_n;
      inst_o       <= inst_n;
      pc_o         <= pco_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, jump_i;
  logic [31:0] jump_addr_i;
  logic [31:0] cache_addr_o, cache_data_i, cache_data_o, mem_addr_o, inst_o, pc_o;
  logic        cache_hit_i, cache_work_o, mem_req_o, mem_valid_i, inst_valid_o;
  logic [7:0]  mem_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .cache_addr_o(cache_addr_o), .cache_data_i(cache_data_i),
    .cache_hit_i(cache_hit_i), .cache_work_o(cache_work_o),
    .cache_data_o(cache_data_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i),
    .mem_data_i(mem_data_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .pc_o(pc_o)
  );

  // Backing memory contents: fixed program bytes at 0..3, hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'd0:   h = 8'h13;
      32'd1:   h = 8'h05;
      32'd2:   h = 8'h00;
      32'd3:   h = 8'h00;
      default: h = (a[7:0] * 8'd29) + a[15:8] + a[31:24] + 8'h3C;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Direct-mapped cache environment, 256 lines of one word.
  logic [31:0] c_data  [256];
  logic [21:0] c_tag   [256];
  logic        c_valid [256];
  logic        flush = 1'b0;
  logic        tb_wr = 1'b0;
  logic [31:0] tb_wr_addr = 32'h0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < 256; i++) c_valid[i] <= 1'b0;
    end else if (tb_wr) begin
      c_valid[tb_wr_addr[9:2]] <= 1'b1;
      c_tag[tb_wr_addr[9:2]]   <= tb_wr_addr[31:10];
      c_data[tb_wr_addr[9:2]]  <= mem_word(tb_wr_addr);
    end else if (cache_work_o) begin
      c_valid[cache_addr_o[9:2]] <= 1'b1;
      c_tag[cache_addr_o[9:2]]   <= cache_addr_o[31:10];
      c_data[cache_addr_o[9:2]]  <= cache_data_o;
      wr_count <= wr_count + 1;
    end
  end

  always_comb begin
    cache_hit_i  = c_valid[cache_addr_o[9:2]] && (c_tag[cache_addr_o[9:2]] == cache_addr_o[31:10]);
    cache_data_i = c_data[cache_addr_o[9:2]];
    mem_data_i   = mem_byte(mem_addr_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a);
    tb_wr = 1'b1; tb_wr_addr = a;
    tick();
    tb_wr = 1'b0;
  endtask

  task automatic test_reset();
    flush = 1'b1; rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = 32'h0; mem_valid_i = 1'b0;
    tick(); tick();
    flush = 1'b0; rst = 1'b0;
    #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc_o got=%h exp=0", pc_o); end
    n_checks++; if (cache_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", cache_addr_o); end
    n_checks++; if (mem_req_o !== 1'b0 || cache_work_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b%b exp=00", mem_req_o, cache_work_o); end
  endtask

  task automatic test_cold_fill();
    tick();  // miss at pc 0
    for (int i = 0; i < 4; i++) begin
      mem_valid_i = 1'b1;
      #1;
      n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(i)) begin n_fail++; $display("FAIL cold_req[%0d] got=%b/%h exp=1/%h", i, mem_req_o, mem_addr_o, 32'(i)); end
      tick();
    end
    mem_valid_i = 1'b0;
    #1;
    n_checks++; if (cache_work_o !== 1'b1 || cache_data_o !== 32'h00000513) begin n_fail++; $display("FAIL cold_write got=%b/%h exp=1/00000513", cache_work_o, cache_data_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL cold_req_off got=%b exp=0", mem_req_o); end
    tick();
    n_checks++; if (cache_work_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL cold_after_write got=%b/%b exp=0/0", cache_work_o, inst_valid_o); end
    tick();
    n_checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00000513 || pc_o !== 32'h0) begin n_fail++; $display("FAIL cold_deliver got=%b/%h/%h exp=1/00000513/0", inst_valid_o, inst_o, pc_o); end
  endtask

  task automatic test_hits();
    rst = 1'b1;
    preload(32'h0); preload(32'h4); preload(32'h8); preload(32'hC);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'(4*i) || inst_o !== mem_word(32'(4*i))) begin n_fail++; $display("FAIL hit[%0d] got=%b/%h/%h exp=1/%h/%h", i, inst_valid_o, pc_o, inst_o, 32'(4*i), mem_word(32'(4*i))); end
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8 || cache_addr_o !== 32'hC) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/8/c", i, inst_valid_o, pc_o, cache_addr_o); end
    end
    stall_i = 1'b0;
    tick();
    n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hC || inst_o !== mem_word(32'hC)) begin n_fail++; $display("FAIL stall_resume got=%b/%h/%h exp=1/c/%h", inst_valid_o, pc_o, inst_o, mem_word(32'hC)); end
  endtask

  task automatic test_jump();
    int wr_before;
    flush = 1'b1; rst = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b0;
    tick();  // miss at 0
    mem_valid_i = 1'b1;
    tick(); tick();  // two bytes in
    jump_i = 1'b1; jump_addr_i = 32'h1003;
    wr_before = wr_count;
    #1;
    n_checks++; if (cache_work_o !== 1'b0) begin n_fail++; $display("FAIL jump_no_write got=%b exp=0", cache_work_o); end
    tick();
    jump_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    n_checks++; if (cache_addr_o !== 32'h1000 || mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_redirect got=%h/%b/%b exp=1000/0/0", cache_addr_o, mem_req_o, inst_valid_o); end
    tick();
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000) begin n_fail++; $display("FAIL jump_newfill got=%b/%h exp=1/1000", mem_req_o, mem_addr_o); end
    mem_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_valid_i = 1'b0;
    #1;
    n_checks++; if (cache_work_o !== 1'b1 || cache_data_o !== mem_word(32'h1000) || cache_addr_o !== 32'h1000) begin n_fail++; $display("FAIL jump_write got=%b/%h/%h exp=1/%h/1000", cache_work_o, cache_data_o, cache_addr_o, mem_word(32'h1000)); end
    tick(); tick();
    n_checks++; if (wr_count - wr_before !== 1) begin n_fail++; $display("FAIL jump_write_count got=%0d exp=1", wr_count - wr_before); end
    n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h1000 || inst_o !== mem_word(32'h1000)) begin n_fail++; $display("FAIL jump_deliver got=%b/%h/%h exp=1/1000/%h", inst_valid_o, pc_o, inst_o, mem_word(32'h1000)); end
  endtask

  task automatic test_rdy();
    flush = 1'b1; rst = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b0;
    tick();  // miss at 0
    mem_valid_i = 1'b1;
    tick();  // byte 0 in
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (mem_req_o !== 1'b0 || cache_work_o !== 1'b0) begin n_fail++; $display("FAIL rdy_freeze[%0d] got=%b/%b exp=0/0", i, mem_req_o, cache_work_o); end
      tick();
    end
    rdy = 1'b1;
    #1;
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1) begin n_fail++; $display("FAIL rdy_resume got=%b/%h exp=1/1", mem_req_o, mem_addr_o); end
    tick(); tick(); tick();
    mem_valid_i = 1'b0;
    #1;
    n_checks++; if (cache_work_o !== 1'b1 || cache_data_o !== 32'h00000513) begin n_fail++; $display("FAIL rdy_write got=%b/%h exp=1/00000513", cache_work_o, cache_data_o); end
    tick(); tick();
    n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00000513) begin n_fail++; $display("FAIL rdy_deliver got=%b/%h/%h exp=1/0/00000513", inst_valid_o, pc_o, inst_o); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    preload(32'hFFFF_FFFC);
    rst = 1'b0;
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFE;
    tick();
    jump_i = 1'b0;
    tick();
    n_checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || cache_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap got=%b/%h/%h exp=1/fffffffc/0", inst_valid_o, pc_o, cache_addr_o); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_inst, m_pco;
    logic        m_fill, m_valid, e_req, e_work;
    logic [7:0]  m_bytes[$];
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0; mem_valid_i = 1'b0;
    tick();
    m_pc = 32'h0; m_inst = 32'h0; m_pco = 32'h0; m_fill = 1'b0; m_valid = 1'b0;
    m_bytes.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = ($urandom_range(0, 199) == 0);
      rdy         = ($urandom_range(0, 9) != 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      jump_i      = ($urandom_range(0, 39) == 0);
      jump_addr_i = 32'($urandom_range(0, 32'h7FF));
      mem_valid_i = 1'($urandom_range(0, 1));
      #1;
      e_req  = rdy && m_fill && (m_bytes.size() < 4);
      e_work = rdy && m_fill && (m_bytes.size() == 4);
      n_checks++; if (cache_addr_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, cache_addr_o, m_pc); end
      n_checks++; if (mem_req_o !== e_req || cache_work_o !== e_work) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b/%b exp=%b/%b", cyc, mem_req_o, cache_work_o, e_req, e_work); end
      if (e_req) begin
        n_checks++; if (mem_addr_o !== m_pc + 32'(m_bytes.size())) begin n_fail++; $display("FAIL rnd_maddr cyc=%0d got=%h exp=%h", cyc, mem_addr_o, m_pc + 32'(m_bytes.size())); end
      end
      if (e_work) begin
        n_checks++; if (cache_data_o !== mem_word(m_pc)) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, cache_data_o, mem_word(m_pc)); end
      end
      // Reference model: a fill is a queue of collected bytes for m_pc.
      if (rst) begin
        m_pc = 32'h0; m_fill = 1'b0; m_bytes.delete();
        m_valid = 1'b0; m_inst = 32'h0; m_pco = 32'h0;
      end else if (rdy) begin
        if (jump_i) begin
          m_pc = jump_addr_i & ~32'h3; m_fill = 1'b0; m_bytes.delete(); m_valid = 1'b0;
        end else if (m_fill) begin
          if (!stall_i) m_valid = 1'b0;
          if (m_bytes.size() == 4) begin
            m_fill = 1'b0; m_bytes.delete();
          end else if (mem_valid_i) begin
            m_bytes.push_back(mem_byte(m_pc + 32'(m_bytes.size())));
          end
        end else if (cache_hit_i) begin
          if (!stall_i) begin
            m_valid = 1'b1; m_inst = mem_word(m_pc); m_pco = m_pc; m_pc = m_pc + 32'd4;
          end
        end else begin
          m_fill = 1'b1;
          if (!stall_i) m_valid = 1'b0;
        end
      end
      tick();
      n_checks++; if (inst_valid_o !== m_valid || pc_o !== m_pco || inst_o !== m_inst) begin n_fail++; $display("FAIL rnd_out cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, inst_valid_o, pc_o, inst_o, m_valid, m_pco, m_inst); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_hits();
    test_stall();
    test_jump();
    test_rdy();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
